// File: rtl/mmio_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmio_bridge_pkg
// Brief   : Shared types and constants for the MMIO bus bridge.
// Revision: 1.0
// ============================================================================
package mmio_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int MMIO_AW   = 21;
   localparam int SLOT_W    = 6;
   localparam int REG_W     = 5;
   localparam int REGION_HI = 31;
   localparam int REGION_LO = 23;

   function automatic logic region_hit(input logic [31:0] addr, input logic [31:0] base);
      return addr[REGION_HI:REGION_LO] == base[REGION_HI:REGION_LO];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : mmio_bridge_if
// Brief   : Processor request/response handshake plus the MMIO strobe bus.
// Revision: 1.0
// ============================================================================
interface mmio_bridge_if;
   import mmio_bridge_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [31:0]        req_addr;
   logic [3:0]         req_be;
   logic [31:0]        req_wdata;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_rdata;
   logic               rsp_err;
   logic               mmio_cs;
   logic               mmio_wr;
   logic               mmio_rd;
   logic [MMIO_AW-1:0] mmio_addr;
   logic [31:0]        mmio_wr_data;
   logic [31:0]        mmio_rd_data;

   // Bridge view
   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready, mmio_rd_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
   );

   // Processor plus MMIO-target view
   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready, mmio_rd_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
   );

endinterface
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mmio_bridge
// Brief   : Single-outstanding processor-to-MMIO bridge with region checking.
// Revision: 1.0
// ============================================================================
module mmio_bridge
   import mmio_bridge_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE = 32'hC000_0000,
   parameter int          RD_LAT    = 0
) (
   input  wire logic   clk,
   input  wire logic   reset,
   mmio_bridge_if.slave bus
);

   state_t r_state;
   state_t w_next;
   logic   r_we;
   logic   w_accept;
   logic   w_legal;

   assign w_accept = (r_state == IDLE) && bus.req_valid;
   assign w_legal  = region_hit(bus.req_addr, MMIO_BASE)
                  && (bus.req_addr[1:0] == 2'b00)
                  && (bus.req_be == 4'hF);

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_legal ? ISSUE : RESP;
         ISSUE:   w_next = (!r_we && RD_LAT != 0) ? RDWAIT : RESP;
         RDWAIT:  w_next = RESP;
         RESP:    if (bus.rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Strobes are loaded on the accept edge so they are high for exactly the ISSUE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we             <= 1'b0;
         bus.rsp_rdata    <= '0;
         bus.rsp_err      <= 1'b0;
         bus.mmio_cs      <= 1'b0;
         bus.mmio_wr      <= 1'b0;
         bus.mmio_rd      <= 1'b0;
         bus.mmio_addr    <= '0;
         bus.mmio_wr_data <= '0;
      end else begin
         bus.mmio_cs <= 1'b0;
         bus.mmio_wr <= 1'b0;
         bus.mmio_rd <= 1'b0;
         if (w_accept) begin
            r_we          <= bus.req_we;
            bus.rsp_rdata <= '0;
            if (w_legal) begin
               bus.rsp_err      <= 1'b0;
               bus.mmio_cs      <= 1'b1;
               bus.mmio_wr      <= bus.req_we;
               bus.mmio_rd      <= !bus.req_we;
               bus.mmio_addr    <= bus.req_addr[22:2];
               bus.mmio_wr_data <= bus.req_wdata;
            end else begin
               bus.rsp_err <= 1'b1;
            end
         end
         if ((r_state == ISSUE && !r_we && RD_LAT == 0) || r_state == RDWAIT)
            bus.rsp_rdata <= bus.mmio_rd_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_bridge
// Brief   : Directed self-checking bench for mmio_bridge, RD_LAT 0 and 1 builds.
// Revision: 1.0
// ============================================================================
module tb_mmio_bridge;
   import mmio_bridge_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mmio_bridge_if bus0();
   mmio_bridge_if bus1();

   mmio_bridge #(.MMIO_BASE(32'hC000_0000), .RD_LAT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
   mmio_bridge #(.MMIO_BASE(32'hC000_0000), .RD_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   logic        sel;
   logic        req_valid, req_we, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;

   assign bus0.req_valid = req_valid & ~sel;
   assign bus1.req_valid = req_valid & sel;
   assign bus0.rsp_ready = rsp_ready & ~sel;
   assign bus1.rsp_ready = rsp_ready & sel;
   assign bus0.req_we = req_we;       assign bus1.req_we = req_we;
   assign bus0.req_addr = req_addr;   assign bus1.req_addr = req_addr;
   assign bus0.req_be = req_be;       assign bus1.req_be = req_be;
   assign bus0.req_wdata = req_wdata; assign bus1.req_wdata = req_wdata;

   function automatic logic [31:0] rd_word(input logic [MMIO_AW-1:0] a);
      return (a == 21'h00061) ? 32'hDEAD_BEEF : 32'h0;
   endfunction

   // RD_LAT=0 target answers in the strobe cycle; RD_LAT=1 target only one cycle later
   assign bus0.mmio_rd_data = bus0.mmio_rd ? rd_word(bus0.mmio_addr) : 32'h0;
   logic               r_pend;
   logic [MMIO_AW-1:0] r_paddr;
   always_ff @(posedge clk) begin
      r_pend  <= bus1.mmio_rd;
      r_paddr <= bus1.mmio_addr;
   end
   assign bus1.mmio_rd_data = r_pend ? rd_word(r_paddr) : 32'h0;

   logic               w_req_ready, w_rsp_valid, w_rsp_err, w_cs, w_wr, w_rd;
   logic [31:0]        w_rdata, w_wdata;
   logic [MMIO_AW-1:0] w_maddr;
   assign w_req_ready = sel ? bus1.req_ready    : bus0.req_ready;
   assign w_rsp_valid = sel ? bus1.rsp_valid    : bus0.rsp_valid;
   assign w_rsp_err   = sel ? bus1.rsp_err      : bus0.rsp_err;
   assign w_rdata     = sel ? bus1.rsp_rdata    : bus0.rsp_rdata;
   assign w_cs        = sel ? bus1.mmio_cs      : bus0.mmio_cs;
   assign w_wr        = sel ? bus1.mmio_wr      : bus0.mmio_wr;
   assign w_rd        = sel ? bus1.mmio_rd      : bus0.mmio_rd;
   assign w_maddr     = sel ? bus1.mmio_addr    : bus0.mmio_addr;
   assign w_wdata     = sel ? bus1.mmio_wr_data : bus0.mmio_wr_data;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   int                 lat, cs_cnt;
   logic               cs_wr, cs_rd;
   logic [MMIO_AW-1:0] cs_addr;
   logic [31:0]        cs_wdata;

   task automatic accept_req(input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
      int n;
      req_we = we; req_addr = addr; req_be = be; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!w_req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", {31'd0, w_req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Counts edges from the accept edge (inclusive) until rsp_valid, recording any strobe.
   task automatic wait_rsp();
      lat = 0; cs_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         if (w_cs) begin
            cs_cnt++; cs_addr = w_maddr; cs_wr = w_wr; cs_rd = w_rd; cs_wdata = w_wdata;
         end
         if (w_rsp_valid) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop",   {31'd0, w_rsp_valid}, 32'd0);
      chk("ready_back", {31'd0, w_req_ready}, 32'd1);
   endtask

   task automatic check_error(input string tag);
      wait_rsp();
      chk({tag, "_lat"},   lat, 1);
      chk({tag, "_cs"},    cs_cnt, 0);
      chk({tag, "_err"},   {31'd0, w_rsp_err}, 32'd1);
      chk({tag, "_rdata"}, w_rdata, 32'd0);
      finish_rsp();
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
      req_addr = '0; req_be = '0; req_wdata = '0;
      #12;
      chk("rst_req_ready", {31'd0, w_req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, w_rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'd0, w_rsp_err},   32'd0);
      chk("rst_cs",        {31'd0, w_cs},        32'd0);
      chk("rst_rdata",     w_rdata,              32'd0);
      chk("rst_maddr",     {11'd0, w_maddr},     32'd0);
      chk("rst_wdata",     w_wdata,              32'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // LED slot write
      accept_req(1'b1, 32'hC000_0100, 4'hF, 32'h0000_00A5);
      wait_rsp();
      chk("wr_lat",   lat, 2);
      chk("wr_cs",    cs_cnt, 1);
      chk("wr_wr",    {31'd0, cs_wr}, 32'd1);
      chk("wr_rd",    {31'd0, cs_rd}, 32'd0);
      chk("wr_addr",  {11'd0, cs_addr}, 32'h0000_0040);
      chk("wr_wdata", cs_wdata, 32'h0000_00A5);
      chk("wr_err",   {31'd0, w_rsp_err}, 32'd0);
      chk("wr_rdata", w_rdata, 32'd0);
      finish_rsp();

      // Read, RD_LAT = 0
      accept_req(1'b0, 32'hC000_0184, 4'hF, 32'h0);
      wait_rsp();
      chk("rd0_lat",   lat, 2);
      chk("rd0_cs",    cs_cnt, 1);
      chk("rd0_rd",    {31'd0, cs_rd}, 32'd1);
      chk("rd0_addr",  {11'd0, cs_addr}, 32'h0000_0061);
      chk("rd0_rdata", w_rdata, 32'hDEAD_BEEF);
      chk("rd0_err",   {31'd0, w_rsp_err}, 32'd0);
      finish_rsp();

      // Read, RD_LAT = 1
      sel = 1'b1;
      accept_req(1'b0, 32'hC000_0184, 4'hF, 32'h0);
      wait_rsp();
      chk("rd1_lat",   lat, 3);
      chk("rd1_cs",    cs_cnt, 1);
      chk("rd1_addr",  {11'd0, cs_addr}, 32'h0000_0061);
      chk("rd1_rdata", w_rdata, 32'hDEAD_BEEF);
      finish_rsp();
      sel = 1'b0;

      accept_req(1'b0, 32'h8000_0000, 4'hF, 32'h0);
      check_error("miss");
      accept_req(1'b0, 32'hC000_0102, 4'hF, 32'h0);
      check_error("misalign");
      accept_req(1'b1, 32'hC000_0100, 4'h3, 32'h1234_5678);
      check_error("partial");

      // Backpressure with a second request waiting
      accept_req(1'b0, 32'hC000_0184, 4'hF, 32'h0);
      wait_rsp();
      chk("bp_lat", lat, 2);
      req_we = 1'b1; req_addr = 32'hC000_0200; req_be = 4'hF; req_wdata = 32'h1234_5678;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, w_rsp_valid}, 32'd1);
         chk("bp_rdata", w_rdata, 32'hDEAD_BEEF);
         chk("bp_ready", {31'd0, w_req_ready}, 32'd0);
         chk("bp_cs",    {31'd0, w_cs}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_idle_ready", {31'd0, w_req_ready}, 32'd1);
      accept_req(1'b1, 32'hC000_0200, 4'hF, 32'h1234_5678);
      wait_rsp();
      chk("bp2_lat",   lat, 2);
      chk("bp2_cs",    cs_cnt, 1);
      chk("bp2_addr",  {11'd0, cs_addr}, 32'h0000_0080);
      chk("bp2_wdata", cs_wdata, 32'h1234_5678);
      finish_rsp();

      // Reset during ISSUE
      accept_req(1'b0, 32'hC000_0184, 4'hF, 32'h0);
      chk("rstmid_cs_pre", {31'd0, w_cs}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rstmid_cs",    {31'd0, w_cs}, 32'd0);
      chk("rstmid_rd",    {31'd0, w_rd}, 32'd0);
      chk("rstmid_valid", {31'd0, w_rsp_valid}, 32'd0);
      @(negedge clk); reset = 1'b0;
      chk("rstmid_ready", {31'd0, w_req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rstmid_stale", {31'd0, w_rsp_valid}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Initiator end of the MMIO bus that feeds the MMIO controller and slot cores.
- Accepts single load/store requests from the processor data port over a valid/ready handshake.
- Checks that the address falls inside the MMIO region and drives the one-cycle mmio_cs/mmio_wr/mmio_rd strobes.
- Captures mmio_rd_data and returns a response (data + error flag) over a second valid/ready handshake. One transaction outstanding at a time.

Parameters:
- MMIO_BASE, 32'hC000_0000, byte base address of the MMIO region; bits [31:23] are compared.
- RD_LAT, 0, read data sampling: 0 = sample mmio_rd_data in the strobe cycle; 1 = sample one cycle after the strobe.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  processor request valid
- req_ready  output  1  bridge can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_be  input  4  byte enables
- req_wdata  input  32  write data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  processor accepts the response
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  access error
- mmio_cs  output  1  MMIO bus select
- mmio_wr  output  1  MMIO write strobe
- mmio_rd  output  1  MMIO read strobe
- mmio_addr  output  21  word address; bits [10:5] = slot, bits [4:0] = register
- mmio_wr_data  output  32  MMIO write data
- mmio_rd_data  input  32  MMIO read data

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values:
  - State = IDLE; req_ready = 1; rsp_valid = 0; rsp_err = 0.
  - mmio_cs, mmio_wr, mmio_rd = 0.
  - rsp_rdata, mmio_addr, mmio_wr_data = 0.
- Reset mid-operation: strobes drop immediately (asynchronously). Any pending or held response is discarded.
- State machine: IDLE, ISSUE, RDWAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid (accept edge), register the request. Address check: hit = req_addr[31:23] == MMIO_BASE[31:23].
  - Legal access (hit, req_addr[1:0] = 0, req_be = 4'hF) -> ISSUE.
  - Otherwise: rsp_err = 1, rsp_rdata = 0 -> RESP. No bus activity.
- ISSUE (exactly one cycle):
  - mmio_cs = 1; mmio_wr = req_we; mmio_rd = !req_we.
  - mmio_addr = req_addr[22:2]; mmio_wr_data = req_wdata.
  - Write -> RESP with rsp_rdata = 0.
  - Read with RD_LAT = 0: capture mmio_rd_data at the end of this cycle -> RESP.
  - Read with RD_LAT = 1: -> RDWAIT.
- RDWAIT:
  - Strobes low; mmio_addr held.
  - Capture mmio_rd_data -> RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE. req_ready returns the following cycle (no same-cycle back-to-back).
- Outside ISSUE, mmio_cs, mmio_wr and mmio_rd are 0. mmio_addr and mmio_wr_data hold their last value.
- req_ready is 0 in every state except IDLE.
- Latency, accept edge to rsp_valid:
  - Write: 2 cycles.
  - Read: 2 cycles (RD_LAT = 0) or 3 cycles (RD_LAT = 1).
  - Error: 1 cycle.
- Requests presented while req_ready = 0 are ignored. The requester must hold them.
- All outputs are registered except req_ready and rsp_valid, which decode from the state register.

Decomposition:
- Package mmio_bridge_pkg:
  - State enum (IDLE, ISSUE, RDWAIT, RESP).
  - MMIO_AW = 21, SLOT_W = 6, REG_W = 5.
  - Constants for the region-compare bit range [31:23].
- Single module; no sub-module is needed.

Test Plan:
- Write to LED slot: req_we = 1, req_addr = 32'hC000_0100, req_be = 4'hF, req_wdata = 32'h0000_00A5 -> one cycle of mmio_cs = 1, mmio_wr = 1, mmio_addr = 21'h00040, mmio_wr_data = 32'hA5. Then rsp_valid 2 cycles after accept with rsp_err = 0, rsp_rdata = 0.
- Read, RD_LAT = 0: req_addr = 32'hC000_0184, mmio_rd_data model returns 32'hDEAD_BEEF -> mmio_rd pulse with mmio_addr = 21'h00061. Then rsp_rdata = 32'hDEAD_BEEF, rsp_err = 0, 2 cycles after accept. Repeat with RD_LAT = 1 and data valid only in the following cycle -> same data, 3 cycles after accept.
- Errors, each with no mmio_cs pulse and rsp_err = 1 after 1 cycle:
  - Region miss: req_addr = 32'h8000_0000.
  - Misaligned: req_addr = 32'hC000_0102.
  - Partial write: req_be = 4'h3.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0, a second req_valid is not accepted. Raising rsp_ready -> IDLE, then the second request is accepted.
- Reset mid-transaction: assert reset during ISSUE -> mmio_cs, mmio_rd and rsp_valid drop immediately. After release, req_ready = 1 and no stale response appears.
